// File: rtl/fac_seq_pkg.sv
// Shared definitions for the factorial job sequencer: FSM state encoding and
// Factorial_Top register offsets.
package fac_seq_pkg;
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_IEN      = 4'd1;
   localparam logic [3:0] ST_FETCH    = 4'd2;
   localparam logic [3:0] ST_FWAIT    = 4'd3;
   localparam logic [3:0] ST_PUSH     = 4'd4;
   localparam logic [3:0] ST_GAP      = 4'd5;
   localparam logic [3:0] ST_START    = 4'd6;
   localparam logic [3:0] ST_WAIT_IRQ = 4'd7;
   localparam logic [3:0] ST_SETTLE1  = 4'd8;
   localparam logic [3:0] ST_SETTLE2  = 4'd9;
   localparam logic [3:0] ST_RD_REQ   = 4'd10;
   localparam logic [3:0] ST_RD_CAP   = 4'd11;
   localparam logic [3:0] ST_STORE    = 4'd12;
   localparam logic [3:0] ST_CLEAR    = 4'd13;
   localparam logic [3:0] ST_FINISH   = 4'd14;

   localparam logic [7:0] OFF_OP_CLEAR = 8'h00;
   localparam logic [7:0] OFF_INT_EN   = 8'h01;
   localparam logic [7:0] OFF_OP_START = 8'h02;
   localparam logic [7:0] OFF_N_FIFO   = 8'h03;
   localparam logic [7:0] OFF_R_FIFO   = 8'h04;
   localparam logic [7:0] OFF_OP_DONE  = 8'h09;
endpackage

// File: rtl/fac_seq_watchdog.sv
// Loadable down-counter; expire is high while enabled and the count is zero.
module fac_seq_watchdog #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire
);
   logic [W-1:0] cnt;

   assign expire = en && (cnt == '0);

   always_ff @(posedge clk or posedge reset)
      if (reset)                    cnt <= '0;
      else if (load)                cnt <= load_val;
      else if (en && cnt != '0)     cnt <= cnt - 1'b1;
endmodule

// File: rtl/fac_seq_ctrl.sv
// Bus-master sequencer running whole factorial jobs on Factorial_Top.
// Optional WAIT_IRQ watchdog enabled by defining FAC_SEQ_TIMEOUT_EN.
module fac_seq_ctrl
   import fac_seq_pkg::*;
#(
   parameter int MAX_N   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  src_addr,
   input  logic [7:0]  dst_addr,
   input  logic [3:0]  count,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        m_req,
   output logic        m_wr,
   output logic [7:0]  m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_grant,
   input  logic [31:0] m_rdata,
   output logic        S_sel,
   output logic        S_wr,
   output logic [7:0]  S_address,
   output logic [31:0] S_din,
   input  logic [31:0] S_dout,
   input  logic        interrupt
);
   localparam logic [3:0] MAX_CNT = 4'(MAX_N);

   logic [3:0]  state;
   logic [7:0]  src, dst;
   logic [3:0]  cnt, i;
   logic [4:0]  k;
   logic [31:0] word;
   logic        tmo;
   logic        wd_expire;

`ifdef FAC_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   fac_seq_watchdog #(.W(WD_W)) u_wd (
      .clk      (clk),
      .reset    (reset),
      .load     (state == ST_START),
      .load_val (WD_W'(TIMEOUT - 1)),
      .en       (state == ST_WAIT_IRQ),
      .expire   (wd_expire)
   );
`else
   logic unused_cfg;
   assign wd_expire  = 1'b0;
   assign unused_cfg = ^TIMEOUT;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         src   <= '0;
         dst   <= '0;
         cnt   <= '0;
         i     <= '0;
         k     <= '0;
         word  <= '0;
         tmo   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE:
               if (start) begin
                  if (count == 4'd0 || count > MAX_CNT) err <= 1'b1;
                  else begin
                     src   <= src_addr;
                     dst   <= dst_addr;
                     cnt   <= count;
                     i     <= '0;
                     k     <= '0;
                     tmo   <= 1'b0;
                     busy  <= 1'b1;
                     state <= ST_IEN;
                  end
               end
            ST_IEN:   state <= ST_FETCH;
            ST_FETCH: if (m_grant) state <= ST_FWAIT;
            ST_FWAIT: begin
               word  <= m_rdata;
               state <= ST_PUSH;
            end
            ST_PUSH: begin
               i     <= i + 4'd1;
               state <= ((i + 4'd1) < cnt) ? ST_FETCH : ST_GAP;
            end
            ST_GAP:   state <= ST_START;
            ST_START: state <= ST_WAIT_IRQ;
            ST_WAIT_IRQ:
               if (interrupt) state <= ST_SETTLE1;
               else if (wd_expire) begin
                  err   <= 1'b1;
                  tmo   <= 1'b1;
                  state <= ST_CLEAR;
               end
            ST_SETTLE1: state <= ST_SETTLE2;
            ST_SETTLE2: state <= ST_RD_REQ;
            ST_RD_REQ:  state <= ST_RD_CAP;
            ST_RD_CAP: begin
               word  <= S_dout;
               state <= ST_STORE;
            end
            ST_STORE:
               if (m_grant) begin
                  k     <= k + 5'd1;
                  state <= ((k + 5'd1) < {cnt, 1'b0}) ? ST_RD_REQ : ST_CLEAR;
               end
            // done and busy change together so FINISH shows done=1, busy=0
            ST_CLEAR: begin
               done  <= ~tmo;
               busy  <= 1'b0;
               state <= ST_FINISH;
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Bus outputs decode from state only, so reset forces them low at once.
   always_comb begin
      m_req     = 1'b0;
      m_wr      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      S_sel     = 1'b0;
      S_wr      = 1'b0;
      S_address = '0;
      S_din     = '0;
      case (state)
         ST_IEN: begin
            S_sel = 1'b1; S_wr = 1'b1; S_address = OFF_INT_EN; S_din = 32'd1;
         end
         ST_FETCH: begin
            m_req = 1'b1; m_addr = src + {4'b0, i};
         end
         ST_PUSH: begin
            S_sel = 1'b1; S_wr = 1'b1; S_address = OFF_N_FIFO; S_din = word;
         end
         ST_START: begin
            S_sel = 1'b1; S_wr = 1'b1; S_address = OFF_OP_START; S_din = 32'd1;
         end
         ST_RD_REQ: begin
            S_sel = 1'b1; S_address = OFF_R_FIFO;
         end
         ST_STORE: begin
            m_req = 1'b1; m_wr = 1'b1; m_addr = dst + {3'b0, k}; m_wdata = word;
         end
         ST_CLEAR: begin
            S_sel = 1'b1; S_wr = 1'b1; S_address = OFF_OP_CLEAR; S_din = 32'd1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_fac_seq_ctrl.sv
// Self-checking bench for fac_seq_ctrl: memory, core and expected-transaction
// model live here; one negedge process checks every bus cycle.
module tb_fac_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  src_addr, dst_addr;
   logic [3:0]  count;
   logic        busy, done, err;
   logic        m_req, m_wr, m_grant;
   logic [7:0]  m_addr;
   logic [31:0] m_wdata, m_rdata;
   logic        S_sel, S_wr, interrupt;
   logic [7:0]  S_address;
   logic [31:0] S_din, S_dout;

   int vectors = 0, miscompares = 0, cyc = 0;

   fac_seq_ctrl #(.MAX_N(8), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .count(count), .busy(busy), .done(done), .err(err), .m_req(m_req), .m_wr(m_wr),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_grant(m_grant), .m_rdata(m_rdata),
      .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address), .S_din(S_din), .S_dout(S_dout),
      .interrupt(interrupt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] fact(input int n);
      logic [63:0] r = 64'd1;
      for (int j = 2; j <= n; j++) r = r * 64'(j);
      return r;
   endfunction

   // ---------------- memory + core model ----------------
   logic [31:0] mem [256];
   logic [39:0] exp_mw[$], exp_sw[$];
   logic [31:0] nfifo[$], rfifo[$];
   logic [31:0] ops [8];
   logic [63:0] mf;
   int  irq_cnt = -1, stall = 0, wait_n = 0, mwr_cnt = 0, bus_cnt = 0, start_cyc = 0;
   bit  no_irq = 0, rd_pend = 0, r_pend = 0, prev_hold = 0, prev_wr = 0, prev_sel = 0;
   logic [7:0]  rd_addr, prev_addr;
   logic [31:0] prev_wdata;

   always @(negedge clk) begin
      if (reset) begin
         m_grant = 0; interrupt = 0; m_rdata = 0; S_dout = 0;
         rd_pend = 0; r_pend = 0; prev_hold = 0; prev_sel = 0; wait_n = 0; irq_cnt = -1;
         nfifo.delete(); rfifo.delete();
      end else begin
         m_rdata = rd_pend ? mem[rd_addr] : $urandom;
         rd_pend = 0;
         S_dout  = (r_pend && rfifo.size() > 0) ? rfifo.pop_front() : $urandom;
         r_pend  = 0;
         if (m_req || S_sel) bus_cnt++;
         if (prev_hold)
            chk("m_hold_stable", {m_req, m_wr, m_addr, m_wdata}, {1'b1, prev_wr, prev_addr, prev_wdata});
         m_grant = 0;
         if (m_req) begin
            if (wait_n >= stall) begin m_grant = 1; wait_n = 0; end
            else wait_n++;
            if (m_grant) begin
               if (m_wr) begin
                  mem[m_addr] = m_wdata;
                  mwr_cnt++;
                  if (exp_mw.size() == 0) begin
                     vectors++; miscompares++;
                     $display("FAIL m_write_extra: addr %0h data %0h, no write expected", m_addr, m_wdata);
                  end else chk("m_write", {m_addr, m_wdata}, exp_mw.pop_front());
               end else begin
                  rd_pend = 1; rd_addr = m_addr;
               end
            end
         end
         prev_hold = m_req && !m_grant;
         prev_wr = m_wr; prev_addr = m_addr; prev_wdata = m_wdata;
         if (S_sel) begin
            chk("s_back_to_back", prev_sel, 0);
            if (S_wr) begin
               if (exp_sw.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL s_write_extra: off %0h data %0h, no write expected", S_address, S_din);
               end else chk("s_write", {S_address, S_din}, exp_sw.pop_front());
               case (S_address)
                  8'h03: nfifo.push_back(S_din);
                  8'h02: begin
                     start_cyc = cyc;
                     foreach (nfifo[j]) begin
                        mf = fact(int'(nfifo[j]));
                        rfifo.push_back(mf[63:32]);
                        rfifo.push_back(mf[31:0]);
                     end
                     nfifo.delete();
                     if (!no_irq) irq_cnt = $urandom_range(1, 10);
                  end
                  8'h00: begin interrupt = 0; irq_cnt = -1; nfifo.delete(); rfifo.delete(); end
                  default: ;
               endcase
            end else begin
               chk("s_read_off", S_address, 8'h04);
               r_pend = 1;
            end
         end
         prev_sel = S_sel;
         if (irq_cnt > 0) irq_cnt--;
         else if (irq_cnt == 0) begin interrupt = 1; irq_cnt = -1; end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_job(input logic [7:0] s, input logic [7:0] d, input int n, input bit wait_done);
      logic [63:0] f;
      logic [7:0]  a;
      int          t;
      for (int j = 0; j < n; j++) begin a = s + 8'(j); mem[a] = ops[j]; end
      exp_sw.push_back({8'h01, 32'd1});
      for (int j = 0; j < n; j++) exp_sw.push_back({8'h03, ops[j]});
      exp_sw.push_back({8'h02, 32'd1});
      for (int j = 0; j < n; j++) begin
         f = fact(int'(ops[j]));
         exp_mw.push_back({d + 8'(2 * j), f[63:32]});
         exp_mw.push_back({d + 8'(2 * j + 1), f[31:0]});
      end
      exp_sw.push_back({8'h00, 32'd1});
      @(negedge clk);
      src_addr = s; dst_addr = d; count = 4'(n); start = 1;
      @(negedge clk);
      start = 0;
      chk("busy_after_start", busy, 1);
      if (wait_done) begin
         t = 0;
         while (!done && t < 5000) begin @(negedge clk); t++; end
         chk("done_seen", done, 1);
         chk("busy_at_done", busy, 0);
         @(negedge clk);
         chk("done_one_cycle", done, 0);
         chk("mw_all_written", exp_mw.size(), 0);
         chk("sw_all_written", exp_sw.size(), 0);
         for (int j = 0; j < n; j++) begin
            f = fact(int'(ops[j]));
            a = d + 8'(2 * j);
            chk("result_hi", mem[a], f[63:32]);
            a = a + 8'd1;
            chk("result_lo", mem[a], f[31:0]);
         end
      end
   endtask

   task automatic illegal(input logic [3:0] n);
      int b;
      @(negedge clk);
      b = bus_cnt;
      count = n; start = 1;
      @(negedge clk);
      start = 0;
      chk("illegal_err", err, 1);
      chk("illegal_busy", busy, 0);
      @(negedge clk);
      chk("illegal_err_once", err, 0);
      repeat (4) @(negedge clk);
      chk("illegal_no_bus", bus_cnt - b, 0);
      chk("illegal_still_idle", busy, 0);
   endtask

   logic [31:0] lit2 [6] = '{32'h0, 32'h78, 32'h0, 32'h1, 32'h21C3677C, 32'h82B40000};

   initial begin
      int n, t, w;
      bit hit, seen_done;
      logic [7:0] s, d, a;
      reset = 1; start = 0; src_addr = 0; dst_addr = 0; count = 0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {busy, done, err, m_req, m_wr, m_addr, S_sel, S_wr, S_address}, 0);
      chk("reset_data", {m_wdata, S_din}, 0);
      reset = 0;
      chk("fact20_pin", fact(20), 64'h21C3677C82B40000);

      // single operand
      ops[0] = 5;
      run_job(8'h10, 8'h20, 1, 1);
      chk("t1_hi", mem[8'h20], 32'h0);
      chk("t1_lo", mem[8'h21], 32'h78);

      // three operands
      ops[0] = 5; ops[1] = 1; ops[2] = 20;
      run_job(8'h30, 8'h40, 3, 1);
      for (int j = 0; j < 6; j++) begin a = 8'h40 + 8'(j); chk("t2_lit", mem[a], lit2[j]); end

      illegal(4'd0);
      illegal(4'd9);

      // stalled memory
      stall = 5;
      for (int j = 0; j < 3; j++) ops[j] = $urandom_range(0, 20);
      run_job(8'h80, 8'h90, 3, 1);

      // random jobs, including address wrap
      for (int r = 0; r < 8; r++) begin
         stall = $urandom_range(0, 3);
         n = $urandom_range(1, 8);
         for (int j = 0; j < n; j++) ops[j] = $urandom_range(0, 20);
         s = (r == 0) ? 8'hFD : 8'($urandom);
         d = (r == 1) ? 8'hFA : 8'($urandom);
         run_job(s, d, n, 1);
      end
      run_job(8'hFE, 8'h00, 8, 1);

      // reset during STORE of k=2
      stall = 1;
      for (int j = 0; j < 4; j++) ops[j] = $urandom_range(0, 20);
      d = 8'h60;
      run_job(8'h50, d, 4, 0);
      t = 0; hit = 0;
      while (!hit && t < 3000) begin
         @(posedge clk); #1;
         hit = m_req && m_wr && (m_addr == d + 8'd2);
         t++;
      end
      chk("reached_store_k2", hit, 1);
      reset = 1; #1;
      chk("midjob_rst_ctrl", {busy, done, err, m_req, m_wr, m_addr, S_sel, S_wr, S_address}, 0);
      chk("midjob_rst_data", {m_wdata, S_din}, 0);
      w = mwr_cnt;
      exp_mw.delete(); exp_sw.delete();
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (30) @(negedge clk);
      chk("no_write_after_reset", mwr_cnt - w, 0);
      chk("idle_after_reset", busy, 0);

      // recovery after abort
      stall = 0;
      ops[0] = 12; ops[1] = 0;
      run_job(8'hA0, 8'hB0, 2, 1);

`ifdef FAC_SEQ_TIMEOUT_EN
      // watchdog: no interrupt, TIMEOUT=64; err registers one cycle after the 64th WAIT_IRQ cycle
      no_irq = 1;
      ops[0] = 7;
      w = mwr_cnt;
      run_job(8'hC0, 8'hD0, 1, 0);
      exp_mw.delete();
      t = 0;
      while (!err && t < 500) begin @(negedge clk); t++; end
      chk("timeout_err", err, 1);
      chk("timeout_latency", cyc - start_cyc, 65);
      seen_done = 0;
      repeat (10) begin @(negedge clk); if (done) seen_done = 1; end
      chk("timeout_no_done", seen_done, 0);
      chk("timeout_clear_written", exp_sw.size(), 0);
      chk("timeout_no_results", mwr_cnt - w, 0);
      chk("timeout_idle", busy, 0);
      no_irq = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
      $fatal(1, "global timeout");
   end
endmodule
